// File: rtl/synth_pkg.sv
// Shared definitions for the player-piano mode controller.
// State encodings, the reset root note and the octave size.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_JAM         = 2'b00,
        ST_COMPOSER    = 2'b01,
        ST_SONG_PLAYER = 2'b10,
        ST_ARM         = 2'b11
    } state_t;

    localparam int unsigned ROOT_MIDDLE_C = 32'd28;
    localparam int unsigned OCTAVE        = 32'd12;

endpackage : synth_pkg

// File: rtl/synth_countin.sv
// Beat counter for the count-in that precedes a recording.
// clr has priority over en; terminal flags the beat that completes the count-in,
// and on that beat the counter wraps back to zero.
module synth_countin #(
    parameter int unsigned BEATS = 32'd4,
    parameter int unsigned CNT_W = 32'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(BEATS - 32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic             term_s;

    assign term_s   = en && (cnt_r == LAST_V);
    assign terminal = term_s;
    assign count    = cnt_r;

    // Count beats while enabled; clear on request or when the final beat lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (term_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule : synth_countin

// File: rtl/synth_mode_ctrl.sv
// Top-level mode controller of the player piano.
// Decodes button pulses into JAM / ARM (count-in) / COMPOSER / SONG_PLAYER,
// holds the transposition root and the selected recording slot, and tracks
// which slots hold a recording. All outputs are registered.
// Optional feature: define SYNTH_OCTAVE_SHIFT_EN to let up+left / up+right
// shift the root by one octave in JAM instead of advancing the slot.
module synth_mode_ctrl
    import synth_pkg::*;
#(
    parameter int unsigned ROOT_W        = 32'd6,
    parameter int unsigned ROOT_MIN      = 32'd1,
    parameter int unsigned ROOT_MAX      = 32'd51,
    parameter int unsigned ROOT_RESET    = ROOT_MIDDLE_C,
    parameter int unsigned NUM_SLOTS     = 32'd4,
    parameter int unsigned COUNTIN_BEATS = 32'd4,
    localparam int unsigned SLOT_W       = $clog2(NUM_SLOTS),
    localparam int unsigned CB_W         = (COUNTIN_BEATS == 32'd0) ? 32'd1 : $clog2(COUNTIN_BEATS + 32'd1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 center_but,
    input  logic                 left_but,
    input  logic                 right_but,
    input  logic                 down_but,
    input  logic                 up_but,
    input  logic                 beat_tick,
    input  logic                 finished_recording,
    input  logic                 playback_done,
    output logic [1:0]           state,
    output logic [ROOT_W-1:0]    root,
    output logic [SLOT_W-1:0]    slot,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic                 done_recording,
    output logic [CB_W-1:0]      countin_beat
);

    localparam logic [ROOT_W-1:0] ROOT_MIN_V   = ROOT_W'(ROOT_MIN);
    localparam logic [ROOT_W-1:0] ROOT_MAX_V   = ROOT_W'(ROOT_MAX);
    localparam logic [ROOT_W-1:0] ROOT_RESET_V = ROOT_W'(ROOT_RESET);

    // True when a root value (one bit wider, to expose overflow) is playable.
    function automatic logic root_in_range(input logic [ROOT_W:0] r);
        return (r >= {1'b0, ROOT_MIN_V}) && (r <= {1'b0, ROOT_MAX_V});
    endfunction

    state_t                 state_r;
    logic [ROOT_W-1:0]      root_r;
    logic [SLOT_W-1:0]      slot_r;
    logic [NUM_SLOTS-1:0]   slot_valid_r;
    logic                   done_r;

    logic                   cnt_clr_s;
    logic                   cnt_en_s;
    logic                   cnt_term_s;
    logic [CB_W-1:0]        cnt_s;
    logic                   abort_s;

`ifdef SYNTH_OCTAVE_SHIFT_EN
    localparam logic [ROOT_W:0] OCT_V = (ROOT_W + 32'd1)'(OCTAVE);
    logic [ROOT_W:0] oct_up_s;
    logic [ROOT_W:0] oct_dn_s;
    assign oct_up_s = {1'b0, root_r} + OCT_V;
    assign oct_dn_s = {1'b0, root_r} - OCT_V;
`endif

    assign abort_s   = center_but || down_but;
    assign cnt_clr_s = (state_r != ST_ARM) || abort_s;
    assign cnt_en_s  = (state_r == ST_ARM) && beat_tick;

    if (COUNTIN_BEATS > 32'd0) begin : g_countin
        synth_countin #(
            .BEATS (COUNTIN_BEATS),
            .CNT_W (CB_W)
        ) u_countin (
            .clk      (clk),
            .reset    (reset),
            .clr      (cnt_clr_s),
            .en       (cnt_en_s),
            .count    (cnt_s),
            .terminal (cnt_term_s)
        );
    end else begin : g_no_countin
        assign cnt_s      = {CB_W{1'b0}};
        assign cnt_term_s = 1'b0;
    end

    // Mode FSM with the root/slot datapath and recording bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_JAM;
            root_r       <= ROOT_RESET_V;
            slot_r       <= {SLOT_W{1'b0}};
            slot_valid_r <= {NUM_SLOTS{1'b0}};
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_JAM: begin
                    if (down_but) begin
                        // Playback only makes sense for a slot that was recorded.
                        if (slot_valid_r[slot_r]) begin
                            state_r <= ST_SONG_PLAYER;
                        end
                    end else if (center_but) begin
                        if (COUNTIN_BEATS == 32'd0) begin
                            state_r <= ST_COMPOSER;
                        end else begin
                            state_r <= ST_ARM;
                        end
                    end else if (up_but) begin
`ifdef SYNTH_OCTAVE_SHIFT_EN
                        if (left_but && !right_but) begin
                            if (({1'b0, root_r} >= OCT_V) && root_in_range(oct_dn_s)) begin
                                root_r <= oct_dn_s[ROOT_W-1:0];
                            end
                        end else if (right_but && !left_but) begin
                            if (root_in_range(oct_up_s)) begin
                                root_r <= oct_up_s[ROOT_W-1:0];
                            end
                        end else begin
                            slot_r <= slot_r + SLOT_W'(1);
                        end
`else
                        slot_r <= slot_r + SLOT_W'(1);
`endif
                    end else if (left_but || right_but) begin
                        if (left_but && !right_but && (root_r > ROOT_MIN_V)) begin
                            root_r <= root_r - ROOT_W'(1);
                        end else if (right_but && !left_but && (root_r < ROOT_MAX_V)) begin
                            root_r <= root_r + ROOT_W'(1);
                        end
                    end else if (!root_in_range({1'b0, root_r})) begin
                        root_r <= ROOT_RESET_V;
                    end
                end
                ST_ARM: begin
                    // Abort beats a coincident final beat; no recording was made.
                    if ((COUNTIN_BEATS == 32'd0) || abort_s) begin
                        state_r <= ST_JAM;
                    end else if (cnt_term_s) begin
                        state_r <= ST_COMPOSER;
                    end
                end
                ST_COMPOSER: begin
                    if (down_but) begin
                        state_r              <= ST_SONG_PLAYER;
                        done_r               <= 1'b1;
                        slot_valid_r[slot_r] <= 1'b1;
                    end else if (center_but || finished_recording) begin
                        state_r              <= ST_JAM;
                        done_r               <= 1'b1;
                        slot_valid_r[slot_r] <= 1'b1;
                    end
                end
                ST_SONG_PLAYER: begin
                    if (down_but || playback_done) begin
                        state_r <= ST_JAM;
                    end
                end
                default: begin
                    state_r <= ST_JAM;
                end
            endcase
        end
    end

    assign state          = state_r;
    assign root           = root_r;
    assign slot           = slot_r;
    assign slot_valid     = slot_valid_r;
    assign done_recording = done_r;
    assign countin_beat   = cnt_s;

endmodule : synth_mode_ctrl

// File: tb/tb_synth_mode_ctrl.sv
// Directed bench for synth_mode_ctrl with default parameters.
// Expected values are hand-computed; octave-shift expectations follow
// SYNTH_OCTAVE_SHIFT_EN as compiled.
module tb_synth_mode_ctrl;

    logic       clk;
    logic       reset;
    logic       center_but, left_but, right_but, down_but, up_but;
    logic       beat_tick, finished_recording, playback_done;
    logic [1:0] state;
    logic [5:0] root;
    logic [1:0] slot;
    logic [3:0] slot_valid;
    logic       done_recording;
    logic [2:0] countin_beat;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [7:0] B_C  = 8'h01;
    localparam logic [7:0] B_L  = 8'h02;
    localparam logic [7:0] B_R  = 8'h04;
    localparam logic [7:0] B_D  = 8'h08;
    localparam logic [7:0] B_U  = 8'h10;
    localparam logic [7:0] B_BT = 8'h20;
    localparam logic [7:0] B_FR = 8'h40;
    localparam logic [7:0] B_PD = 8'h80;

    synth_mode_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .center_but         (center_but),
        .left_but           (left_but),
        .right_but          (right_but),
        .down_but           (down_but),
        .up_but             (up_but),
        .beat_tick          (beat_tick),
        .finished_recording (finished_recording),
        .playback_done      (playback_done),
        .state              (state),
        .root               (root),
        .slot               (slot),
        .slot_valid         (slot_valid),
        .done_recording     (done_recording),
        .countin_beat       (countin_beat)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a set of one-cycle pulses across exactly one rising edge.
    // Returns at the following falling edge, where outputs are sampled.
    task automatic pulse(input logic [7:0] v);
        @(negedge clk);
        center_but         = v[0];
        left_but           = v[1];
        right_but          = v[2];
        down_but           = v[3];
        up_but             = v[4];
        beat_tick          = v[5];
        finished_recording = v[6];
        playback_done      = v[7];
        @(negedge clk);
        {playback_done, finished_recording, beat_tick, up_but, down_but, left_but, right_but, center_but} = 8'h00;
    endtask

    task automatic pulse_n(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) pulse(v);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {playback_done, finished_recording, beat_tick, up_but, down_but, left_but, right_but, center_but} = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (state !== 2'b00) begin n_mis++; $display("FAIL reset_state got %b want 00", state); end
        n_cmp++; if (root !== 6'd28) begin n_mis++; $display("FAIL reset_root got %0d want 28", root); end
        n_cmp++; if (slot !== 2'd0) begin n_mis++; $display("FAIL reset_slot got %0d want 0", slot); end
        n_cmp++; if (slot_valid !== 4'b0000) begin n_mis++; $display("FAIL reset_valid got %b want 0000", slot_valid); end
        n_cmp++; if (done_recording !== 1'b0 || countin_beat !== 3'd0) begin n_mis++; $display("FAIL reset_done_cnt got %b/%0d want 0/0", done_recording, countin_beat); end
    endtask

    task automatic test_root_range();
        pulse_n(B_R, 23);
        n_cmp++; if (root !== 6'd51) begin n_mis++; $display("FAIL root_up_to_max got %0d want 51", root); end
        pulse(B_R);
        n_cmp++; if (root !== 6'd51) begin n_mis++; $display("FAIL root_clamp_max got %0d want 51", root); end
        pulse_n(B_L, 50);
        n_cmp++; if (root !== 6'd1) begin n_mis++; $display("FAIL root_down_to_min got %0d want 1", root); end
        pulse(B_L);
        n_cmp++; if (root !== 6'd1) begin n_mis++; $display("FAIL root_clamp_min got %0d want 1", root); end
        pulse_n(B_R, 44);
        n_cmp++; if (root !== 6'd45) begin n_mis++; $display("FAIL root_to_45 got %0d want 45", root); end
        pulse(B_L | B_R);
        n_cmp++; if (root !== 6'd45) begin n_mis++; $display("FAIL root_left_right got %0d want 45", root); end
    endtask

    task automatic test_jam_slot();
        pulse(B_D);
        n_cmp++; if (state !== 2'b00) begin n_mis++; $display("FAIL down_no_valid got %b want 00", state); end
        pulse_n(B_U, 5);
        n_cmp++; if (slot !== 2'd1) begin n_mis++; $display("FAIL slot_wrap got %0d want 1", slot); end
    endtask

    task automatic test_record();
        pulse(B_C);
        n_cmp++; if (state !== 2'b11 || countin_beat !== 3'd0) begin n_mis++; $display("FAIL arm_entry got %b/%0d want 11/0", state, countin_beat); end
        pulse_n(B_BT, 3);
        n_cmp++; if (state !== 2'b11 || countin_beat !== 3'd3) begin n_mis++; $display("FAIL arm_3_beats got %b/%0d want 11/3", state, countin_beat); end
        pulse(B_BT);
        n_cmp++; if (state !== 2'b01 || countin_beat !== 3'd0) begin n_mis++; $display("FAIL arm_to_composer got %b/%0d want 01/0", state, countin_beat); end
        pulse(B_L);
        n_cmp++; if (root !== 6'd45 || state !== 2'b01) begin n_mis++; $display("FAIL composer_root_frozen got %0d/%b want 45/01", root, state); end
        pulse(B_FR);
        n_cmp++; if (state !== 2'b00 || done_recording !== 1'b1) begin n_mis++; $display("FAIL finish_rec got %b/%b want 00/1", state, done_recording); end
        n_cmp++; if (slot_valid !== 4'b0010) begin n_mis++; $display("FAIL valid_slot1 got %b want 0010", slot_valid); end
        pulse(8'h00);
        n_cmp++; if (done_recording !== 1'b0) begin n_mis++; $display("FAIL done_one_cycle got %b want 0", done_recording); end
        pulse(B_D);
        n_cmp++; if (state !== 2'b10) begin n_mis++; $display("FAIL jam_to_play got %b want 10", state); end
        pulse(B_C | B_U | B_FR);
        n_cmp++; if (state !== 2'b10 || slot !== 2'd1) begin n_mis++; $display("FAIL play_ignores got %b/%0d want 10/1", state, slot); end
        pulse(B_PD);
        n_cmp++; if (state !== 2'b00) begin n_mis++; $display("FAIL play_done got %b want 00", state); end
    endtask

    task automatic test_abort();
        pulse(B_C);
        pulse_n(B_BT, 2);
        n_cmp++; if (countin_beat !== 3'd2) begin n_mis++; $display("FAIL abort_pre_cnt got %0d want 2", countin_beat); end
        pulse(B_D | B_BT);
        n_cmp++; if (state !== 2'b00 || done_recording !== 1'b0) begin n_mis++; $display("FAIL abort_state got %b/%b want 00/0", state, done_recording); end
        n_cmp++; if (slot_valid !== 4'b0010 || countin_beat !== 3'd0) begin n_mis++; $display("FAIL abort_valid got %b/%0d want 0010/0", slot_valid, countin_beat); end
        // Abort on the terminal beat must still win.
        pulse(B_C);
        pulse_n(B_BT, 3);
        pulse(B_C | B_BT);
        n_cmp++; if (state !== 2'b00 || done_recording !== 1'b0) begin n_mis++; $display("FAIL abort_last_beat got %b/%b want 00/0", state, done_recording); end
    endtask

    task automatic test_composer_down_finished();
        pulse(B_U);
        pulse(B_C);
        pulse_n(B_BT, 4);
        pulse(B_D | B_FR);
        n_cmp++; if (state !== 2'b10 || done_recording !== 1'b1) begin n_mis++; $display("FAIL down_fin got %b/%b want 10/1", state, done_recording); end
        n_cmp++; if (slot_valid !== 4'b0110) begin n_mis++; $display("FAIL valid_slot2 got %b want 0110", slot_valid); end
        pulse(8'h00);
        n_cmp++; if (done_recording !== 1'b0) begin n_mis++; $display("FAIL down_fin_single got %b want 0", done_recording); end
        pulse(B_D);
        n_cmp++; if (state !== 2'b00) begin n_mis++; $display("FAIL play_down_exit got %b want 00", state); end
    endtask

    task automatic test_octave();
        pulse(B_U | B_R);
`ifdef SYNTH_OCTAVE_SHIFT_EN
        n_cmp++; if (root !== 6'd45 || slot !== 2'd2) begin n_mis++; $display("FAIL oct_up_blocked got %0d/%0d want 45/2", root, slot); end
`else
        n_cmp++; if (root !== 6'd45 || slot !== 2'd3) begin n_mis++; $display("FAIL up_right_as_up got %0d/%0d want 45/3", root, slot); end
`endif
        pulse(B_U | B_L);
`ifdef SYNTH_OCTAVE_SHIFT_EN
        n_cmp++; if (root !== 6'd33 || slot !== 2'd2) begin n_mis++; $display("FAIL oct_down got %0d/%0d want 33/2", root, slot); end
`else
        n_cmp++; if (root !== 6'd45 || slot !== 2'd0) begin n_mis++; $display("FAIL up_left_as_up got %0d/%0d want 45/0", root, slot); end
`endif
    endtask

    task automatic test_reset_mid_recording();
        pulse(B_C);
        pulse_n(B_BT, 4);
        n_cmp++; if (state !== 2'b01) begin n_mis++; $display("FAIL mid_rec_setup got %b want 01", state); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (state !== 2'b00 || slot_valid !== 4'b0000 || done_recording !== 1'b0) begin n_mis++; $display("FAIL mid_rec_reset got %b/%b/%b want 00/0000/0", state, slot_valid, done_recording); end
        @(negedge clk);
        reset = 1'b1;
        pulse(8'h00);
        n_cmp++; if (done_recording !== 1'b0 || root !== 6'd28) begin n_mis++; $display("FAIL post_reset got %b/%0d want 0/28", done_recording, root); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_root_range();
        test_jam_slot();
        test_record();
        test_abort();
        test_composer_down_finished();
        test_octave();
        test_reset_mid_recording();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_synth_mode_ctrl
